// File: rtl/fft_pkg.sv
// Constants and helpers shared by the FFT datapath blocks.
package fft_pkg;

  localparam int unsigned DefaultWidth    = 16;
  localparam int unsigned DefaultMaxDepth = 32;

  // Width that can represent every delay or count from 0 to max_depth inclusive.
  function automatic int unsigned delay_width(input int unsigned max_depth);
    return $clog2(max_depth) + 1;
  endfunction

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one synchronous write port and one combinational read port.
module dual_port_ram #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 32,
  localparam int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 i_clock,
  input  logic                 i_wr_en,
  input  logic [AddrWidth-1:0] i_wr_addr,
  input  logic [DataWidth-1:0] i_wr_data,
  input  logic [AddrWidth-1:0] i_rd_addr,
  output logic [DataWidth-1:0] o_rd_data
);

  logic [DataWidth-1:0] r_mem [Depth];

  always_ff @(posedge i_clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/programmable_delay_buffer.sv
// Delays a complex sample stream by a run-time programmable number of accepted samples,
// using a circular buffer and a fill counter that gates the output valid pulse.
module programmable_delay_buffer
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH         = DefaultWidth,
  parameter int unsigned MAX_DEPTH     = DefaultMaxDepth,
  parameter int unsigned DEFAULT_DELAY = DefaultMaxDepth,
  localparam int unsigned DW = delay_width(MAX_DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_input_valid,
  input  logic [WIDTH-1:0] data_input_real,
  input  logic [WIDTH-1:0] data_input_complex,
  input  logic             delay_load,
  input  logic [DW-1:0]    delay_length,
  output logic             data_output_valid,
  output logic [WIDTH-1:0] data_output_real,
  output logic [WIDTH-1:0] data_output_complex,
  output logic [DW-1:0]    fill_level
);

  localparam int unsigned AW = $clog2(MAX_DEPTH);

  logic [AW-1:0]      r_wr_ptr;
  logic [DW-1:0]      r_fill;
  logic [DW-1:0]      r_delay;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_real;
  logic [WIDTH-1:0]   r_out_imag;

  logic [DW-1:0]      w_load_delay;
  logic [DW-1:0]      w_delay;
  logic [DW-1:0]      w_fill_next;
  logic [AW-1:0]      w_rd_addr;
  logic               w_wr_en;
  logic [2*WIDTH-1:0] w_wr_data;
  logic [2*WIDTH-1:0] w_rd_data;
  logic [2*WIDTH-1:0] w_out_data;

  always_comb begin
    w_load_delay = delay_length;
    if (delay_length == '0) begin
      w_load_delay = DW'(1);
    end else if (delay_length > DW'(MAX_DEPTH)) begin
      w_load_delay = DW'(MAX_DEPTH);
    end
  end

  // A load takes effect on the same edge, including for a coincident sample.
  assign w_delay   = delay_load ? w_load_delay : r_delay;
  assign w_rd_addr = r_wr_ptr - AW'(w_delay - DW'(1));
  assign w_wr_en   = data_input_valid && !reset;
  assign w_wr_data = {data_input_real, data_input_complex};

  always_comb begin
    w_fill_next = r_fill;
    if (delay_load) begin
      w_fill_next = data_input_valid ? DW'(1) : '0;
    end else if (data_input_valid && (r_fill != DW'(MAX_DEPTH))) begin
      w_fill_next = r_fill + DW'(1);
    end
  end

  // With D=1 the read address is the slot being written this edge, so bypass the RAM.
  assign w_out_data = (w_delay == DW'(1)) ? w_wr_data : w_rd_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_delay     <= DW'(DEFAULT_DELAY);
      r_out_valid <= 1'b0;
      r_out_real  <= '0;
      r_out_imag  <= '0;
    end else begin
      r_fill      <= w_fill_next;
      r_out_valid <= data_input_valid && !delay_load && (w_fill_next >= w_delay);
      if (delay_load) begin
        r_delay <= w_load_delay;
      end
      if (data_input_valid) begin
        r_wr_ptr                 <= r_wr_ptr + AW'(1);
        {r_out_real, r_out_imag} <= w_out_data;
      end
    end
  end

  dual_port_ram #(
    .DataWidth (2 * WIDTH),
    .Depth     (MAX_DEPTH)
  ) u_ram (
    .i_clock   (clock),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign data_output_valid   = r_out_valid;
  assign data_output_real    = r_out_real;
  assign data_output_complex = r_out_imag;
  assign fill_level          = r_fill;

endmodule

// File: tb/tb_programmable_delay_buffer.sv
// Self-checking bench: reference model with an output scoreboard plus a table of
// hand-computed vectors for the short-delay and gapped-input cases.
module tb_programmable_delay_buffer;

  localparam int unsigned WIDTH         = 16;
  localparam int unsigned MAX_DEPTH     = 32;
  localparam int unsigned DEFAULT_DELAY = 32;
  localparam int unsigned DW            = 6;

  logic             clock;
  logic             reset;
  logic             data_input_valid;
  logic [WIDTH-1:0] data_input_real;
  logic [WIDTH-1:0] data_input_complex;
  logic             delay_load;
  logic [DW-1:0]    delay_length;
  logic             data_output_valid;
  logic [WIDTH-1:0] data_output_real;
  logic [WIDTH-1:0] data_output_complex;
  logic [DW-1:0]    fill_level;

  programmable_delay_buffer #(
    .WIDTH         (WIDTH),
    .MAX_DEPTH     (MAX_DEPTH),
    .DEFAULT_DELAY (DEFAULT_DELAY)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .data_input_valid    (data_input_valid),
    .data_input_real     (data_input_real),
    .data_input_complex  (data_input_complex),
    .delay_load          (delay_load),
    .delay_length        (delay_length),
    .data_output_valid   (data_output_valid),
    .data_output_real    (data_output_real),
    .data_output_complex (data_output_complex),
    .fill_level          (fill_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  // Reference model state.
  logic [31:0] m_hist[$];
  logic [31:0] sb_q[$];
  int          m_delay = DEFAULT_DELAY;
  int          m_fill  = 0;
  logic [31:0] m_out   = '0;
  logic        m_known = 1'b1;

  typedef struct {
    logic        v;
    logic [15:0] re;
    logic        ld;
    logic [5:0]  len;
    logic        exp_v;
    logic [5:0]  exp_fill;
    logic        chk_data;
    logic [15:0] exp_re;
  } vec_t;

  vec_t vecs[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic int clamp(input int len);
    if (len == 0) return 1;
    if (len > int'(MAX_DEPTH)) return int'(MAX_DEPTH);
    return len;
  endfunction

  task automatic step(input logic rst, input logic v, input logic [15:0] re, input logic ld,
                      input logic [5:0] len);
    logic        exp_v;
    logic [31:0] exp_d;
    reset              = rst;
    data_input_valid   = v;
    data_input_real    = re;
    data_input_complex = ~re;
    delay_load         = ld;
    delay_length       = len;
    @(posedge clock);
    exp_v = 1'b0;
    if (rst) begin
      m_hist.delete();
      m_fill  = 0;
      m_delay = DEFAULT_DELAY;
      m_out   = '0;
      m_known = 1'b1;
    end else begin
      if (ld) m_delay = clamp(int'(len));
      if (v) begin
        m_hist.push_back({re, ~re});
        if (m_hist.size() >= m_delay) begin
          m_out   = m_hist[m_hist.size() - m_delay];
          m_known = 1'b1;
        end else begin
          m_known = 1'b0;
        end
      end
      if (ld) m_fill = v ? 1 : 0;
      else if (v && m_fill < int'(MAX_DEPTH)) m_fill++;
      exp_v = v && !ld && (m_fill >= m_delay);
      if (exp_v) sb_q.push_back(m_out);
    end
    #1;
    chk("valid", 32'(data_output_valid), 32'(exp_v));
    chk("fill_level", 32'(fill_level), 32'(m_fill));
    if (data_output_valid) begin
      n_pulses++;
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", 32'(1), 32'(0));
      end else begin
        exp_d = sb_q.pop_front();
        chk("pulse_data", {data_output_real, data_output_complex}, exp_d);
      end
    end
    if (m_known) chk("out_data", {data_output_real, data_output_complex}, m_out);
  endtask

  task automatic stream(input int first, input int count);
    for (int i = 0; i < count; i++) step(1'b0, 1'b1, 16'(first + i), 1'b0, '0);
  endtask

  initial begin
    int p0;
    // D=1 case: each output is the sample just accepted.
    vecs.push_back('{1'b0, 16'd0,  1'b1, 6'd1, 1'b0, 6'd0, 1'b0, 16'd0});
    vecs.push_back('{1'b1, 16'd5,  1'b0, 6'd0, 1'b1, 6'd1, 1'b1, 16'd5});
    vecs.push_back('{1'b1, 16'd6,  1'b0, 6'd0, 1'b1, 6'd2, 1'b1, 16'd6});
    vecs.push_back('{1'b1, 16'd7,  1'b0, 6'd0, 1'b1, 6'd3, 1'b1, 16'd7});
    // D=4 with valid toggling: output is sample n-3 and holds in the gaps.
    vecs.push_back('{1'b0, 16'd0,  1'b1, 6'd4, 1'b0, 6'd0, 1'b0, 16'd0});
    vecs.push_back('{1'b1, 16'd10, 1'b0, 6'd0, 1'b0, 6'd1, 1'b0, 16'd0});
    vecs.push_back('{1'b0, 16'd0,  1'b0, 6'd9, 1'b0, 6'd1, 1'b0, 16'd0});
    vecs.push_back('{1'b1, 16'd11, 1'b0, 6'd0, 1'b0, 6'd2, 1'b0, 16'd0});
    vecs.push_back('{1'b0, 16'd0,  1'b0, 6'd0, 1'b0, 6'd2, 1'b0, 16'd0});
    vecs.push_back('{1'b1, 16'd12, 1'b0, 6'd0, 1'b0, 6'd3, 1'b0, 16'd0});
    vecs.push_back('{1'b0, 16'd0,  1'b0, 6'd0, 1'b0, 6'd3, 1'b0, 16'd0});
    vecs.push_back('{1'b1, 16'd13, 1'b0, 6'd0, 1'b1, 6'd4, 1'b1, 16'd10});
    vecs.push_back('{1'b0, 16'd0,  1'b0, 6'd0, 1'b0, 6'd4, 1'b1, 16'd10});
    vecs.push_back('{1'b1, 16'd14, 1'b0, 6'd0, 1'b1, 6'd5, 1'b1, 16'd11});
    vecs.push_back('{1'b0, 16'd0,  1'b0, 6'd0, 1'b0, 6'd5, 1'b1, 16'd11});

    // Reset state.
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    chk("reset_out", {data_output_real, data_output_complex}, 32'h0);

    // Default D=32: samples 1..40 give pulses carrying 1..9.
    p0 = n_pulses;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 1'b1, 16'(i), 1'b0, '0);
      if (i == 31) chk("d32_no_pulse_at_31", 32'(data_output_valid), 32'(0));
      if (i == 32) chk("d32_first_data", 32'(data_output_real), 32'(1));
    end
    chk("d32_pulse_count", 32'(n_pulses - p0), 32'(9));
    chk("d32_last_data", 32'(data_output_real), 32'(9));

    foreach (vecs[k]) begin
      step(1'b0, vecs[k].v, vecs[k].re, vecs[k].ld, vecs[k].len);
      chk($sformatf("tbl%0d_valid", k), 32'(data_output_valid), 32'(vecs[k].exp_v));
      chk($sformatf("tbl%0d_fill", k), 32'(fill_level), 32'(vecs[k].exp_fill));
      if (vecs[k].chk_data)
        chk($sformatf("tbl%0d_real", k), 32'(data_output_real), 32'(vecs[k].exp_re));
    end

    // Clamping: length 0 acts as 1, length 50 acts as 32; fill saturates at 32.
    step(1'b0, 1'b0, '0, 1'b1, 6'd0);
    step(1'b0, 1'b1, 16'd20, 1'b0, '0);
    chk("clamp0_valid", 32'(data_output_valid), 32'(1));
    chk("clamp0_data", 32'(data_output_real), 32'(20));
    step(1'b0, 1'b0, '0, 1'b1, 6'd50);
    p0 = n_pulses;
    stream(100, 40);
    chk("clamp50_pulses", 32'(n_pulses - p0), 32'(9));
    chk("fill_saturated", 32'(fill_level), 32'(32));

    // Load of 8 coincident with a sample: that sample starts the new fill.
    step(1'b0, 1'b1, 16'd200, 1'b1, 6'd8);
    chk("load8_fill", 32'(fill_level), 32'(1));
    p0 = n_pulses;
    stream(201, 7);
    chk("load8_one_pulse", 32'(n_pulses - p0), 32'(1));
    chk("load8_data", 32'(data_output_real), 32'(200));
    stream(208, 40);

    // Reset mid-stream with valid high.
    step(1'b1, 1'b1, 16'd999, 1'b0, '0);
    chk("midreset_out", {data_output_real, data_output_complex}, 32'h0);
    chk("midreset_fill", 32'(fill_level), 32'(0));
    p0 = n_pulses;
    stream(300, 31);
    chk("midreset_no_pulse", 32'(n_pulses - p0), 32'(0));
    stream(331, 3);
    chk("midreset_pulses", 32'(n_pulses - p0), 32'(3));
    chk("midreset_data", 32'(data_output_real), 32'(302));

    chk("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
